// File: rtl/shared_timer_scheduler.sv
// Shares one up-counter between NUM_REQ requesters: round-robin grant, run to the
// winner's terminal count, then pulse done or cancelled back to that owner.
module shared_timer_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 32,
  parameter int OWN_W   = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*CNT_W-1:0] req_count,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic                     enable,
  input  logic                     cancel,
  output logic [NUM_REQ-1:0]       done,
  output logic [NUM_REQ-1:0]       cancelled,
  output logic                     busy,
  output logic [OWN_W-1:0]         owner,
  output logic [CNT_W-1:0]         count
);

  typedef enum logic [1:0] {IDLE, RUN, DONE, CXL} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] target;
  logic [OWN_W-1:0] rr_ptr;
  logic [OWN_W-1:0] cand;
  logic [OWN_W-1:0] grant_idx;
  logic             grant_any;
  logic [NUM_REQ-1:0] grant_oh;
  logic [CNT_W-1:0] tgt_sel;
  logic             at_target;

  assign at_target = (count == target);

  // Walk from the lowest-priority slot back to rr_ptr+1 so the last hit is the winner.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    cand      = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    if (state == IDLE) begin
      for (int k = NUM_REQ; k >= 1; k--) begin
        cand = OWN_W'((int'(rr_ptr) + k) % NUM_REQ);
        if (req_valid[cand]) begin
          grant_any = 1'b1;
          grant_idx = cand;
        end
      end
    end
  end

  always_comb begin
    grant_oh  = '0;
    tgt_sel   = '0;
    done      = '0;
    cancelled = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_oh[i]  = grant_any && (grant_idx == OWN_W'(i));
      if (grant_oh[i]) tgt_sel = req_count[i*CNT_W +: CNT_W];
      done[i]      = (state == DONE) && (owner == OWN_W'(i));
      cancelled[i] = (state == CXL)  && (owner == OWN_W'(i));
    end
  end

  assign req_ready = grant_oh;
  assign busy      = (state == RUN) || (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (grant_any) state_nxt = RUN;
      RUN: begin
        if (at_target)   state_nxt = DONE;
        else if (cancel) state_nxt = CXL;
      end
      DONE:    state_nxt = IDLE;
      CXL:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count  <= '0;
      target <= '0;
      owner  <= '0;
      rr_ptr <= OWN_W'(NUM_REQ - 1);
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      case (state)
        IDLE: if (grant_any) begin
          target <= tgt_sel;
          count  <= '0;
          owner  <= grant_idx;
          rr_ptr <= grant_idx;
        end
        RUN: if (!at_target && !cancel && enable) count <= count + CNT_W'(1);
        default: ;
      endcase
    end
  end

  a_ready_onehot: assert property (@(posedge clk) disable iff (!resetn) $onehot0(req_ready));
  a_done_onehot:  assert property (@(posedge clk) disable iff (!resetn) $onehot0(done));
  a_cxl_onehot:   assert property (@(posedge clk) disable iff (!resetn) $onehot0(cancelled));
  a_cnt_bound:    assert property (@(posedge clk) disable iff (!resetn)
                                   (state == RUN) |-> (count <= target));
  // A grant starts a run for that owner; a run only leaves through DONE or CXL, each back to IDLE.
  a_grant_run:    assert property (@(posedge clk) disable iff (!resetn)
                                   grant_any |=> (state == RUN) && (owner == $past(grant_idx)));
  a_run_exit:     assert property (@(posedge clk) disable iff (!resetn)
                                   (state == RUN) |=> (state inside {RUN, DONE, CXL}));
  a_pulse_once:   assert property (@(posedge clk) disable iff (!resetn)
                                   (state inside {DONE, CXL}) |=> (state == IDLE));
  a_owner_hold:   assert property (@(posedge clk) disable iff (!resetn)
                                   (state != IDLE) |=> $stable(owner));

endmodule
